// File: rtl/dbg_reg_arb_if.sv
// rtl/dbg_reg_arb_if.sv - requester and core-side signal bundle for the debug register arbiter
interface dbg_reg_arb_if;
  logic        req_0, req_1;
  logic        we_0, we_1;
  logic [11:0] idx_0, idx_1;
  logic [31:0] wdata_0, wdata_1;
  logic        ack_0, ack_1;
  logic        err_0, err_1;
  logic [31:0] rdata;
  logic        core_halted;
  logic        debug_read, debug_write;
  logic [11:0] register_index;
  logic [31:0] debug_wdata;
  logic [31:0] debug_rdata;
  logic        reg_rack, reg_wack;

  modport slave (
    input  req_0, req_1, we_0, we_1, idx_0, idx_1, wdata_0, wdata_1,
    input  core_halted, debug_rdata, reg_rack, reg_wack,
    output ack_0, ack_1, err_0, err_1, rdata,
    output debug_read, debug_write, register_index, debug_wdata
  );

  modport master (
    output req_0, req_1, we_0, we_1, idx_0, idx_1, wdata_0, wdata_1,
    output core_halted, debug_rdata, reg_rack, reg_wack,
    input  ack_0, ack_1, err_0, err_1, rdata,
    input  debug_read, debug_write, register_index, debug_wdata
  );
endinterface

// File: rtl/dbg_reg_arb.sv
// rtl/dbg_reg_arb.sv - two-requester round-robin arbiter for core debug register accesses
module dbg_reg_arb #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset,
  dbg_reg_arb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_e;

  state_e      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [11:0] ridx_q, ridx_d;
  logic [31:0] rwd_q, rwd_d;
  logic [1:0]  ack_q, ack_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic        any_req, sel, sel_we, done, gnt_req;
  logic [11:0] sel_idx;
  logic [31:0] sel_wdata;
  logic [7:0]  cnt_inc;

  // On a tie the requester that did not win last time is chosen.
  assign any_req   = bus.req_0 | bus.req_1;
  assign sel       = (bus.req_0 & bus.req_1) ? ~last_q : bus.req_1;
  assign sel_we    = sel ? bus.we_1 : bus.we_0;
  assign sel_idx   = sel ? bus.idx_1 : bus.idx_0;
  assign sel_wdata = sel ? bus.wdata_1 : bus.wdata_0;
  assign done      = (rd_q & bus.reg_rack) | (wr_q & bus.reg_wack);
  assign gnt_req   = gnt_q ? bus.req_1 : bus.req_0;
  assign cnt_inc   = cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    ridx_d  = ridx_q;
    rwd_d   = rwd_q;
    ack_d   = ack_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d  = sel;
          last_d = sel;
          if (bus.core_halted) begin
            state_d = ACCESS;
            cnt_d   = 8'd0;
            rd_d    = ~sel_we;
            wr_d    = sel_we;
            ridx_d  = sel_idx;
            rwd_d   = sel_we ? sel_wdata : 32'd0;
          end else begin
            state_d      = ACK;
            ack_d[sel]   = 1'b1;
            err_d[sel]   = 1'b1;
            rdata_d      = 32'd0;
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_inc;
        // A matching core ack takes priority over an expiring timeout.
        if (done || cnt_inc == 8'(TIMEOUT)) begin
          state_d      = ACK;
          rd_d         = 1'b0;
          wr_d         = 1'b0;
          ridx_d       = 12'd0;
          rwd_d        = 32'd0;
          ack_d[gnt_q] = 1'b1;
          err_d[gnt_q] = ~done;
          rdata_d      = (done & rd_q) ? bus.debug_rdata : 32'd0;
        end
      end
      ACK: begin
        if (!gnt_req) begin
          state_d = IDLE;
          ack_d   = 2'b00;
          err_d   = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= 8'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ridx_q  <= 12'd0;
      rwd_q   <= 32'd0;
      ack_q   <= 2'b00;
      err_q   <= 2'b00;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ridx_q  <= ridx_d;
      rwd_q   <= rwd_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.ack_0          = ack_q[0];
  assign bus.ack_1          = ack_q[1];
  assign bus.err_0          = err_q[0];
  assign bus.err_1          = err_q[1];
  assign bus.rdata          = rdata_q;
  assign bus.debug_read     = rd_q;
  assign bus.debug_write    = wr_q;
  assign bus.register_index = ridx_q;
  assign bus.debug_wdata    = rwd_q;
endmodule

// File: tb/tb_dbg_reg_arb.sv
// tb/tb_dbg_reg_arb.sv - randomized self-checking bench for dbg_reg_arb against a transaction model
module tb_dbg_reg_arb;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dbg_reg_arb_if bus ();
  dbg_reg_arb #(.TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Transaction-level model: pending requests, round-robin memory, last completed data.
  bit          last_grant = 1'b1;
  bit          pend [2];
  bit          p_we [2];
  logic [11:0] p_idx [2];
  logic [31:0] p_wd [2];
  logic [31:0] m_rdata = 32'd0;

  task automatic drive(input int r, input bit q, input bit we, input logic [11:0] idx, input logic [31:0] wd);
    if (r == 0) begin
      bus.req_0 = q; bus.we_0 = we; bus.idx_0 = idx; bus.wdata_0 = wd;
    end else begin
      bus.req_1 = q; bus.we_1 = we; bus.idx_1 = idx; bus.wdata_1 = wd;
    end
  endtask

  task automatic set_req(input int r, input bit q);
    if (r == 0) bus.req_0 = q; else bus.req_1 = q;
  endtask

  function automatic logic get_ack(input int r);
    return (r == 0) ? bus.ack_0 : bus.ack_1;
  endfunction

  function automatic logic get_err(input int r);
    return (r == 0) ? bus.err_0 : bus.err_1;
  endfunction

  task automatic new_req(input int r, input bit we, input logic [11:0] idx);
    pend[r]  = 1'b1;
    p_we[r]  = we;
    p_idx[r] = idx;
    p_wd[r]  = $urandom;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_ack0"}, bus.ack_0, 0);
    check_eq({tag, "_ack1"}, bus.ack_1, 0);
    check_eq({tag, "_err0"}, bus.err_0, 0);
    check_eq({tag, "_err1"}, bus.err_1, 0);
    check_eq({tag, "_rdata"}, bus.rdata, 0);
    check_eq({tag, "_dread"}, bus.debug_read, 0);
    check_eq({tag, "_dwrite"}, bus.debug_write, 0);
    check_eq({tag, "_index"}, bus.register_index, 0);
    check_eq({tag, "_dwdata"}, bus.debug_wdata, 0);
  endtask

  // Serves one request from the pending set; called at a falling edge with the arbiter idle.
  // dly: strobe cycles before the core acks (ack lands in strobe cycle dly+1).
  task automatic serve_one(input bit halted, input int dly, input bit drop_in);
    int w, o, n, exp_n;
    bit exp_err, drop_early;
    logic [31:0] exp_rd;
    drop_early = drop_in & halted;
    for (int r = 0; r < 2; r++) drive(r, pend[r], p_we[r], p_idx[r], p_wd[r]);
    bus.core_halted = halted;
    w = (pend[0] && pend[1]) ? (last_grant ? 0 : 1) : (pend[1] ? 1 : 0);
    o = 1 - w;
    last_grant = w[0];
    exp_n   = !halted ? 0 : ((dly + 1 <= TO) ? dly + 1 : TO);
    exp_err = !halted || (dly + 1 > TO);
    exp_rd  = 32'd0;
    @(negedge clk);
    drive(w, 1'b1, $urandom, $urandom, $urandom);
    drive(o, pend[o], $urandom, $urandom, $urandom);
    n = 0;
    while (!get_ack(w) && n < 64) begin
      check_eq("strobe_read", bus.debug_read, halted && !p_we[w]);
      check_eq("strobe_write", bus.debug_write, halted && p_we[w]);
      check_eq("strobe_index", bus.register_index, halted ? p_idx[w] : 12'd0);
      check_eq("strobe_wdata", bus.debug_wdata, (halted && p_we[w]) ? p_wd[w] : 32'd0);
      check_eq("loser_ack", get_ack(o), 0);
      bus.debug_rdata = $urandom;
      if (p_we[w]) begin
        bus.reg_wack = (n == dly);
        bus.reg_rack = $urandom;
      end else begin
        bus.reg_rack = (n == dly);
        bus.reg_wack = $urandom;
        if (n == dly) exp_rd = bus.debug_rdata;
      end
      if (drop_early && n == 0) set_req(w, 1'b0);
      n++;
      @(negedge clk);
    end
    bus.reg_rack = 1'b0;
    bus.reg_wack = 1'b0;
    if (!exp_err && !p_we[w]) m_rdata = exp_rd; else m_rdata = 32'd0;
    check_eq("ack_seen", get_ack(w), 1);
    check_eq("strobe_cycles", n, exp_n);
    check_eq("ack_err", get_err(w), exp_err);
    check_eq("ack_rdata", bus.rdata, m_rdata);
    check_eq("loser_ack_at_ack", get_ack(o), 0);
    check_eq("loser_err_at_ack", get_err(o), 0);
    check_eq("strobe_off_read", bus.debug_read, 0);
    check_eq("strobe_off_write", bus.debug_write, 0);
    if (!drop_early) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check_eq("ack_held", get_ack(w), 1);
        check_eq("err_held", get_err(w), exp_err);
        check_eq("strobe_once", bus.debug_read | bus.debug_write, 0);
      end
      set_req(w, 1'b0);
    end
    @(negedge clk);
    check_eq("ack_dropped", get_ack(w), 0);
    check_eq("err_dropped", get_err(w), 0);
    check_eq("rdata_kept", bus.rdata, m_rdata);
    pend[w] = 1'b0;
  endtask

  task automatic reset_mid();
    new_req(1, 1'b1, $urandom);
    pend[0] = 1'b0;
    for (int r = 0; r < 2; r++) drive(r, pend[r], p_we[r], p_idx[r], p_wd[r]);
    bus.core_halted = 1'b1;
    bus.reg_rack = 1'b0;
    bus.reg_wack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_mid_write", bus.debug_write, 1);
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 12'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 12'd0, 32'd0);
    @(negedge clk);
    check_quiet("rst_mid");
    reset = 1'b0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    last_grant = 1'b1;
    m_rdata = 32'd0;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 12'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 12'd0, 32'd0);
    bus.core_halted = 1'b0;
    bus.debug_rdata = 32'd0;
    bus.reg_rack = 1'b0;
    bus.reg_wack = 1'b0;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    reset = 1'b0;
    @(negedge clk);

    // Tie straight out of reset: requester 0 first, then 1, then 0 again on the next tie.
    new_req(0, 1'b1, 12'h001);
    new_req(1, 1'b1, 12'h002);
    serve_one(1'b1, 1, 1'b0);
    serve_one(1'b1, 0, 1'b0);
    new_req(0, 1'b1, 12'h001);
    new_req(1, 1'b1, 12'h002);
    serve_one(1'b1, 0, 1'b0);
    serve_one(1'b1, 0, 1'b0);

    new_req(0, 1'b0, 12'h7B0);
    serve_one(1'b1, 2, 1'b0);
    new_req(0, 1'b1, 12'h123);
    serve_one(1'b1, 99, 1'b0);
    new_req(1, 1'b0, 12'h456);
    serve_one(1'b0, 0, 1'b0);
    new_req(0, 1'b0, 12'h321);
    serve_one(1'b1, 3, 1'b0);
    new_req(1, 1'b1, 12'h0AA);
    serve_one(1'b1, 1, 1'b1);

    reset_mid();
    new_req(1, 1'b0, 12'h055);
    serve_one(1'b1, 1, 1'b0);

    for (int it = 0; it < 200; it++) begin
      if (it % 50 == 49) reset_mid();
      for (int r = 0; r < 2; r++)
        if (!pend[r] && $urandom_range(0, 1) == 1) new_req(r, $urandom, $urandom);
      if (!pend[0] && !pend[1]) new_req($urandom_range(0, 1), $urandom, $urandom);
      serve_one($urandom_range(0, 4) != 0, $urandom_range(0, 5), $urandom_range(0, 3) == 0);
    end
    while (pend[0] || pend[1]) serve_one(1'b1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
